// File: rtl/mdu_pkg.sv
// ============================================================================
// Package     : mdu_pkg
// Description : Shared operation codes, FSM state encoding, reset defaults and
//               opcode-decode helpers for the iterative multiply/divide unit.
//               Optional macro MDU_MADD_EN enables the MADD/MSUB family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [4:0] OP_NONE  = 5'd0;
    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MFLO  = 5'd6;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;
    localparam logic [4:0] OP_MADD  = 5'd9;
    localparam logic [4:0] OP_MADDU = 5'd10;
    localparam logic [4:0] OP_MSUB  = 5'd11;
    localparam logic [4:0] OP_MSUBU = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_DIV_FIX  = 2'd3
    } mdu_state_t;

    // How a finished product is merged into {HI,LO}
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_t;

    // Reset defaults
    localparam logic RST_HILO_BIT = 1'b0;
    localparam logic RST_DONE     = 1'b0;

    function automatic logic is_mul_op(input logic [4:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic acc_mode_t acc_mode_of(input logic [4:0] op);
        acc_mode_t m;
        m = ACC_NONE;
        if ((op == OP_MADD) || (op == OP_MADDU)) m = ACC_ADD;
        if ((op == OP_MSUB) || (op == OP_MSUBU)) m = ACC_SUB;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_iter.sv
// ============================================================================
// Module      : mdu_div_iter
// Description : Restoring divider, one quotient bit per step. Magnitudes are
//               divided; sign and divide-by-zero results are applied on the
//               combinational outputs, which are valid after the last step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             step,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dividend_q;  // original dividend, returned on divide-by-zero
    logic [IW-1:0]    cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             zero_q;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Operand magnitudes and the trial subtraction of one restoring step
    always_comb begin
        abs_a   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_b   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        fits    = ~trial[WIDTH];
    end

    // Operand capture on start, then one shift/subtract step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            dividend_q <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
        end else if (start) begin
            quo_q      <= abs_a;
            dvs_q      <= abs_b;
            rem_q      <= '0;
            dividend_q <= dividend;
            cnt_q      <= IW'(WIDTH - 1);
            neg_quo_q  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q  <= is_signed && dividend[WIDTH-1];
            zero_q     <= (divisor == '0);
        end else if (step) begin
            rem_q <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign last = (cnt_q == '0);

    // Sign fix-up; MIN / -1 falls out naturally as quotient MIN, remainder 0
    always_comb begin
        if (zero_q) begin
            quotient  = '1;
            remainder = dividend_q;
        end else begin
            quotient  = neg_quo_q ? -quo_q : quo_q;
            remainder = neg_rem_q ? -rem_q : rem_q;
        end
    end

endmodule

`default_nettype wire

// File: rtl/e_mdu_iter.sv
// ============================================================================
// Module      : e_mdu_iter
// Description : EX-stage multiply/divide unit owning HI/LO. Multiply completes
//               after MUL_LAT cycles; division is iterative (WIDTH steps plus
//               one sign fix-up cycle). Optional macro MDU_MADD_EN adds
//               MADD/MADDU/MSUB/MSUBU accumulating into {HI,LO}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_req,
    input  logic             i_start,
    input  logic [4:0]       i_mdu_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    mdu_state_t         state;
    mdu_state_t         state_nxt;

    logic               accept;
    logic               mul_accept;
    logic               div_accept;
    logic               mul_done;
    logic               div_done;

    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_signed;
    logic [CW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mul_wr;

    logic               div_last;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

`ifdef MDU_MADD_EN
    acc_mode_t          acc_mode;
`endif

    assign accept     = i_start && !i_req && (state == ST_IDLE) &&
                        (is_mul_op(i_mdu_op) || is_div_op(i_mdu_op));
    assign mul_accept = accept && is_mul_op(i_mdu_op);
    assign div_accept = accept && is_div_op(i_mdu_op);
    assign o_busy     = (state != ST_IDLE);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next state and completion strobes
    always_comb begin
        state_nxt = state;
        mul_done  = 1'b0;
        div_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mul_accept)      state_nxt = ST_MUL;
                else if (div_accept) state_nxt = ST_DIV_ITER;
            end
            ST_MUL: begin
                if (mul_cnt == '0) begin
                    mul_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DIV_ITER: begin
                if (div_last) state_nxt = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                div_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Multiply operand capture and latency countdown
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            mul_cnt    <= '0;
        end else if (mul_accept) begin
            mul_a      <= i_src_a;
            mul_b      <= i_src_b;
            mul_signed <= is_signed_op(i_mdu_op);
            mul_cnt    <= CW'(MUL_LAT - 1);
        end else if ((state == ST_MUL) && (mul_cnt != '0)) begin
            mul_cnt    <= mul_cnt - 1'b1;
        end
    end

`ifdef MDU_MADD_EN
    // Accumulate mode of the multiply in flight
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)      acc_mode <= ACC_NONE;
        else if (mul_accept) acc_mode <= acc_mode_of(i_mdu_op);
    end
`endif

    // Full-width product; extension to 2*WIDTH makes the truncated product exact
    always_comb begin
        ext_a   = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
        ext_b   = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
        product = ext_a * ext_b;
        mul_wr  = product;
`ifdef MDU_MADD_EN
        if (acc_mode == ACC_ADD)      mul_wr = {o_hi, o_lo} + product;
        else if (acc_mode == ACC_SUB) mul_wr = {o_hi, o_lo} - product;
`endif
    end

    mdu_div_iter #(
        .WIDTH     (WIDTH)
    ) u_div (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .start     (div_accept),
        .is_signed (is_signed_op(i_mdu_op)),
        .dividend  (i_src_a),
        .divisor   (i_src_b),
        .step      (state == ST_DIV_ITER),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // HI/LO update: a completing operation wins over a same-cycle MT write
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hi   <= {WIDTH{RST_HILO_BIT}};
            o_lo   <= {WIDTH{RST_HILO_BIT}};
            o_done <= RST_DONE;
        end else begin
            o_done <= mul_done || div_done;
            if (mul_done) begin
                {o_hi, o_lo} <= mul_wr;
            end else if (div_done) begin
                o_hi <= div_rem;
                o_lo <= div_quo;
            end else if (!i_req) begin
                if (i_mdu_op == OP_MTHI) o_hi <= i_src_a;
                if (i_mdu_op == OP_MTLO) o_lo <= i_src_a;
            end
        end
    end

    // Move-from result path
    always_comb begin
        o_result = '0;
        if (i_mdu_op == OP_MFHI)      o_result = o_hi;
        else if (i_mdu_op == OP_MFLO) o_result = o_lo;
    end

endmodule

`default_nettype wire

// File: doc/e_mdu_iter.md
Name: e_mdu_iter

Overview:
- Parametrised successor to the E-stage multiply/divide unit.
- Multiply uses a configurable-latency product pipeline. Division is a true iterative restoring divider producing one quotient bit per cycle.
- Owns the HI/LO registers and supports MFHI/MFLO/MTHI/MTLO.
- Sits in EX beside the ALU. The hazard unit stalls on (i_start | o_busy), and i_req blocks side effects of the instruction currently in EX.

Parameters:
WIDTH, 32, operand/HI/LO width; even, >= 8
MUL_LAT, 5, cycles from multiply start to HI/LO write; >= 1

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_req  in  1  exception/interrupt request; suppresses start and MT writes this cycle
i_start  in  1  start MULT/MULTU/DIV/DIVU (or MADD family) this cycle
i_mdu_op  in  5  operation code (shared package)
i_src_a  in  WIDTH  rs operand / dividend / MT source
i_src_b  in  WIDTH  rt operand / divisor
o_hi  out  WIDTH  HI register
o_lo  out  WIDTH  LO register
o_result  out  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0
o_busy  out  1  operation in flight
o_done  out  1  one-cycle pulse, registered, on the cycle after HI/LO are written

Behaviour:
- Clock and reset: one clock (i_clk); reset is asynchronous and active-low (i_reset_n).
- Reset, including mid-operation: o_hi=0, o_lo=0, o_busy=0, o_done=0, FSM=IDLE. Any in-flight result is discarded.
- FSM states: IDLE, MUL, DIV_ITER, DIV_FIX.
- Start acceptance:
  - A start is accepted at edge t0 only when i_start && !i_req && FSM==IDLE and i_mdu_op is a start op.
  - i_start is ignored while busy; there is no queueing.
  - Operands are latched at t0, and o_busy=1 from t0.
- MUL/MULTU:
  - A counter loads MUL_LAT-1. The full 2*WIDTH product is computed signed or unsigned.
  - At edge t0+MUL_LAT: {HI,LO}<=product, o_busy<=0, o_done<=1 for one cycle, FSM->IDLE.
- DIV/DIVU:
  - t0 latches |a|, |b| and the sign flags (signed op only). The remainder register is cleared.
  - DIV_ITER runs WIDTH cycles. Each cycle does a restoring step (shift, trial subtract, quotient bit), with an iteration counter from WIDTH-1 down to 0.
  - DIV_FIX (1 cycle) applies the sign: quotient negated if signs differ; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder written at edge t0+WIDTH+1, with o_busy falling at the same edge.
- Divide by zero (either div op): LO = all ones, HI = dividend (i_src_a as latched). Same latency.
- Signed overflow (MIN / -1): LO=MIN, HI=0.
- MTHI/MTLO:
  - When !i_req, HI or LO <= i_src_a at the edge. This applies even while busy.
  - The in-flight op's later write overwrites it; the pipeline is responsible for stalling.
- i_req: blocks start and MT writes in the same cycle. It does not affect an already-accepted op, which continues to completion.
- o_result is purely combinational from current HI/LO. The new value is visible the cycle after the write edge.
- Back-to-back: the next start can be accepted at the edge after o_busy falls, i.e. the first cycle o_busy==0.
- Ops NONE/MF*/MT* with i_start=1 do not start and do not raise busy.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD/MADDU/MSUB/MSUBU.
  - Multiply path and latency are the same as MUL.
  - At completion: {HI,LO} <= {HI,LO} ± product, using the HI/LO values current at the completion edge, mod 2^(2*WIDTH).
- Undefined: these codes behave as NONE (no start, no busy, no write).

Decomposition:
- Shared package mdu_pkg holds:
  - op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12;
  - FSM state encoding;
  - reset-default constants.
- One natural sub-module: mdu_div_iter. It contains the restoring divider datapath and iteration counter, with start/done handshake, abs/sign handling and zero-divisor handling.

Test Plan:
- MULT -3 x 7, WIDTH=32, MUL_LAT=5 -> o_busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_done pulses once.
- DIV -7 / 2 -> busy 33 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIVU 0xFFFFFFFF/0x10 -> LO=0x0FFFFFFF, HI=0xF.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- i_start with MULT and i_req=1 -> no busy, HI/LO unchanged. MTHI 0x1234 with i_req=1 -> HI unchanged. With i_req=0 -> MFHI result 0x1234 next cycle.
- Assert i_reset_n=0 asynchronously mid-DIV (iteration 10) -> o_busy, o_hi and o_lo drop to 0 immediately, without waiting for a clock edge. A new MULTU 2x3 after release -> LO=6, HI=0.
- With MDU_MADD_EN, HI=0, LO=10, MSUBU 3x4 -> LO=0xFFFFFFFE, HI=0xFFFFFFFF. Without the macro, same stimulus -> no busy, HI/LO unchanged.
